// File: rtl/bram_pkg.sv
// bram_pkg: shared types and constants for sdp_bram_clr.
//   state_t      - clear-engine FSM state (ST_CLEAR, ST_READY)
//   RD_LAT_1/2   - the only read latencies the pipeline supports
//   params_ok()  - elaboration-time legality check on RD_LATENCY and DEPTH
package bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

  // True when the latency is supported and DEPTH words fit in the address space.
  function automatic bit params_ok(input int rd_latency, input int depth,
                                   input int addr_width);
    bit lat_ok;
    bit depth_ok;
    lat_ok   = (rd_latency == RD_LAT_1) || (rd_latency == RD_LAT_2);
    depth_ok = (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_width));
    return lat_ok && depth_ok;
  endfunction

endpackage

// File: rtl/bram_array.sv
// bram_array: raw simple-dual-port storage, written so synthesis maps it onto
// vendor block RAM. No reset, one synchronous write port and one synchronous
// read port with a read enable; the read register only changes on i_re.
// A read and a write to the same address at the same edge return the old
// contents (read-first).
// Ports:
//   i_clk    clock
//   i_we     write enable      i_waddr / i_wdata  write address / data
//   i_re     read enable       i_raddr            read address
//   o_rdata  registered read data, held while i_re is low
module bram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sdp_bram_clr.sv
// sdp_bram_clr: single-clock simple-dual-port RAM with a clear engine that
// sweeps every word to INIT_VALUE after reset or on clr_req.
//
// Optional feature: define BRAM_WR_FWD_EN for write-first collision behaviour
// (a read colliding with a user write returns the new dina). Without it the
// RAM is read-first and no forwarding mux exists.
//
// Ports:
//   clka        clock (rising edge)        rsta        async active-high reset
//   wea/addra/dina  write port A           reb/addrb   read port B
//   doutb       read data (held when doutb_valid=0)
//   doutb_valid doutb carries a read result this cycle
//   clr_req     one-cycle clear request (honoured only when not busy)
//   busy        clear sweep in progress
//   addr_err    one-cycle pulse after an out-of-range access was dropped
//   dbg_state   current FSM state, for observation only
//
// Handshake: there is no per-port ready. busy is the inverse of ready for both
// ports: wea/reb are accepted on an edge only if busy is low at that edge, and
// are silently dropped otherwise (no write, no read, no addr_err). An accepted
// read always produces exactly one doutb_valid cycle RD_LATENCY cycles later.
module sdp_bram_clr
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DEPTH      = 1000,
  parameter int                    RD_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  addr_err,
  output state_t                dbg_state
);

  generate
    if (!params_ok(RD_LATENCY, DEPTH, ADDR_WIDTH)) begin : g_bad_params
      $error("sdp_bram_clr: RD_LATENCY must be 1 or 2 and DEPTH <= 2**ADDR_WIDTH");
    end
  endgenerate

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  w_busy;

  logic                  w_wa_ok;
  logic                  w_rb_ok;
  logic                  w_usr_we;
  logic                  w_rd_go;
  logic                  w_oor;

  logic                  w_arr_we;
  logic [ADDR_WIDTH-1:0] w_arr_waddr;
  logic [DATA_WIDTH-1:0] w_arr_wdata;
  logic                  w_arr_re;
  logic [ADDR_WIDTH-1:0] w_arr_raddr;
  logic [DATA_WIDTH-1:0] w_arr_q;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic                  r_dv;
  logic                  r_have;
  logic                  r_addr_err;

  // ---------------------------------------------------------------- FSM
  assign w_busy = (r_state == ST_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_ptr == LP_LAST) w_state_nxt = ST_READY;
      ST_READY: if (clr_req)          w_state_nxt = ST_CLEAR;
      default:                        w_state_nxt = ST_CLEAR;
    endcase
  end

  // The pointer advances only while sweeping and rests at 0 otherwise, so a
  // new sweep (reset or clr_req) always starts from address 0.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy && (r_ptr != LP_LAST)) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end else begin
        r_ptr <= '0;
      end
    end
  end

  // ------------------------------------------ range checks / arbitration
  assign w_wa_ok  = ({1'b0, addra} < LP_DEPTH);
  assign w_rb_ok  = ({1'b0, addrb} < LP_DEPTH);
  assign w_usr_we = !w_busy && wea && w_wa_ok;
  assign w_rd_go  = !w_busy && reb && w_rb_ok;
  assign w_oor    = !w_busy && ((wea && !w_wa_ok) || (reb && !w_rb_ok));

  // The clear engine owns the write port for the whole sweep.
  assign w_arr_we    = w_busy || w_usr_we;
  assign w_arr_waddr = w_busy ? r_ptr      : addra;
  assign w_arr_wdata = w_busy ? INIT_VALUE : dina;

  // ------------------------------------------------- latency pipeline
  // w_arr_re marks the edge at which the array is actually read; doutb_valid
  // follows it by one edge in both latency modes.
  generate
    if (RD_LATENCY == RD_LAT_2) begin : g_lat2
      logic                  r_s1_vld;
      logic [ADDR_WIDTH-1:0] r_s1_addr;

      // A read accepted just before a clr_req still reads the array on the
      // next edge even though busy is then high; it completes normally.
      always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
          r_s1_vld  <= 1'b0;
          r_s1_addr <= '0;
        end else begin
          r_s1_vld <= w_rd_go;
          if (w_rd_go) begin
            r_s1_addr <= addrb;
          end
        end
      end

      assign w_arr_re    = r_s1_vld;
      assign w_arr_raddr = r_s1_addr;
    end else begin : g_lat1
      assign w_arr_re    = w_rd_go;
      assign w_arr_raddr = addrb;
    end
  endgenerate

  bram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .i_clk   (clka),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_re    (w_arr_re),
    .i_raddr (w_arr_raddr),
    .o_rdata (w_arr_q)
  );

  // --------------------------------------------------- forwarding path
`ifdef BRAM_WR_FWD_EN
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  // Captured alongside the array read so the choice is held with doutb.
  // Only user writes are forwarded; clear-engine writes never are.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else if (w_arr_re) begin
      r_fwd_hit  <= w_usr_we && (addra == w_arr_raddr);
      r_fwd_data <= dina;
    end
  end

  assign w_rd_data = r_fwd_hit ? r_fwd_data : w_arr_q;
`else
  assign w_rd_data = w_arr_q;
`endif

  // ------------------------------------------------------------ outputs
  // The array read register has no reset; r_have masks it to zero until the
  // first read after reset lands.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_dv       <= 1'b0;
      r_have     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_dv       <= w_arr_re;
      r_addr_err <= w_oor;
      if (w_arr_re) begin
        r_have <= 1'b1;
      end
    end
  end

  assign doutb       = r_have ? w_rd_data : '0;
  assign doutb_valid = r_dv;
  assign busy        = w_busy;
  assign addr_err    = r_addr_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sdp_bram_clr.sv
// tb_sdp_bram_clr: two instances of sdp_bram_clr (RD_LATENCY 2 and 1) driven
// by the same inputs. Directed vector table for the main read/write/collision
// and range behaviour, plus hand-written sequences for the clear sweep,
// clr_req while busy and reset in the middle of a sweep.
module tb_sdp_bram_clr;
  import bram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

`ifdef BRAM_WR_FWD_EN
  localparam logic [DW-1:0] COL1 = 8'h22;  // latency-1 collision result
  localparam logic [DW-1:0] COL2 = 8'h33;  // latency-2 collision result
`else
  localparam logic [DW-1:0] COL1 = 8'h11;
  localparam logic [DW-1:0] COL2 = 8'h22;
`endif

  // ---------------------------------------------------- clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          reb;
  logic [AW-1:0] addrb;
  logic          clr_req;

  logic [DW-1:0] doutb2, doutb1;
  logic          dv2, dv1;
  logic          busy2, busy1;
  logic          err2, err1;
  state_t        st2, st1;

  sdp_bram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(2),
                 .INIT_VALUE(8'h00)) u_dut2 (
    .clka(clk), .rsta(rst), .wea(wea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(doutb2), .doutb_valid(dv2),
    .clr_req(clr_req), .busy(busy2), .addr_err(err2), .dbg_state(st2)
  );

  sdp_bram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1),
                 .INIT_VALUE(8'h00)) u_dut1 (
    .clka(clk), .rsta(rst), .wea(wea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(doutb1), .doutb_valid(dv1),
    .clr_req(clr_req), .busy(busy1), .addr_err(err1), .dbg_state(st1)
  );

  // ------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] exp_q2[$];
  logic [DW-1:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ----------------------------------------------------- vector table
  typedef struct {
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          reb;
    logic [AW-1:0] addrb;
    logic          v2;
    logic [DW-1:0] d2;
    logic          v1;
    logic [DW-1:0] d1;
    logic          err;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic w, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic r, input logic [AW-1:0] ab,
                              input logic v2, input logic [DW-1:0] d2,
                              input logic v1, input logic [DW-1:0] d1, input logic e);
    vec_t v;
    v.wea = w;  v.addra = aa; v.dina = da; v.reb = r; v.addrb = ab;
    v.v2  = v2; v.d2 = d2; v.v1 = v1; v.d1 = d1; v.err = e;
    return v;
  endfunction

  // ---------------------------------------------------- driver tasks
  task automatic idle_inputs();
    wea     = 1'b0;
    reb     = 1'b0;
    clr_req = 1'b0;
  endtask

  // Drive one cycle of inputs, then check the outputs seen during that cycle.
  task automatic run_row(input vec_t v, input int idx);
    @(posedge clk); #1;
    wea = v.wea; addra = v.addra; dina = v.dina;
    reb = v.reb; addrb = v.addrb; clr_req = 1'b0;
    @(negedge clk);
    check($sformatf("row%0d_busy", idx), 32'({busy2, busy1}), 32'(0));
    check($sformatf("row%0d_v2", idx),   32'(dv2),  32'(v.v2));
    check($sformatf("row%0d_v1", idx),   32'(dv1),  32'(v.v1));
    check($sformatf("row%0d_err2", idx), 32'(err2), 32'(v.err));
    check($sformatf("row%0d_err1", idx), 32'(err1), 32'(v.err));
    if (v.v2) check($sformatf("row%0d_d2", idx), 32'(doutb2), 32'(v.d2));
    if (v.v1) check($sformatf("row%0d_d1", idx), 32'(doutb1), 32'(v.d1));
  endtask

  // Count cycles with busy high, starting in the cycle after a reset release
  // or clr_req edge. Bounded; an overrun shows up as a wrong count.
  task automatic count_busy(output int n2, output int n1);
    n2 = 0;
    n1 = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy2) n2++;
      if (busy1) n1++;
      if (!busy2 && !busy1) break;
    end
  endtask

  // Back-to-back reads of rb_addr[0..n-1], expected INIT_VALUE (0), checked
  // through the expected queues as doutb_valid arrives.
  logic [AW-1:0] rb_addr[8];

  task automatic readback(input int n, input string tag);
    int got2;
    int got1;
    got2 = 0;
    got1 = 0;
    for (int i = 0; i < n + 4; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (i < n) begin
        reb   = 1'b1;
        addrb = rb_addr[i];
        exp_q2.push_back(8'h00);
        exp_q1.push_back(8'h00);
      end
      @(negedge clk);
      if (dv2) begin
        got2++;
        if (exp_q2.size() == 0) check({tag, "_extra_v2"}, 32'(1), 32'(0));
        else check($sformatf("%s_d2_%0d", tag, got2), 32'(doutb2), 32'(exp_q2.pop_front()));
      end
      if (dv1) begin
        got1++;
        if (exp_q1.size() == 0) check({tag, "_extra_v1"}, 32'(1), 32'(0));
        else check($sformatf("%s_d1_%0d", tag, got1), 32'(doutb1), 32'(exp_q1.pop_front()));
      end
    end
    check({tag, "_left2"}, 32'(exp_q2.size()), 32'(0));
    check({tag, "_left1"}, 32'(exp_q1.size()), 32'(0));
  endtask

  // ------------------------------------------------------------- test
  initial begin
    int n2, n1, nv2, nv1, ne;
    logic [DW-1:0] d2, d1;

    rst = 1'b1; wea = 1'b0; addra = '0; dina = '0;
    reb = 1'b0; addrb = '0; clr_req = 1'b0;

    tbl[0]  = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd0,    1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd500,  1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    tbl[2]  = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd999,  1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    tbl[3]  = mk(1'b1, 10'd3,    8'hA5, 1'b0, 10'd0,    1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    tbl[4]  = mk(1'b1, 10'd999,  8'h5A, 1'b0, 10'd0,    1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[5]  = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[6]  = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd999,  1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
    tbl[7]  = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 8'hA5, 1'b1, 8'h5A, 1'b0);
    tbl[8]  = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    tbl[9]  = mk(1'b1, 10'd7,    8'h11, 1'b0, 10'd0,    1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[10] = mk(1'b1, 10'd7,    8'h22, 1'b1, 10'd7,    1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[11] = mk(1'b1, 10'd7,    8'h33, 1'b0, 10'd0,    1'b0, 8'h00, 1'b1, COL1,  1'b0);
    tbl[12] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, COL2,  1'b0, 8'h00, 1'b0);
    tbl[13] = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd7,    1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[14] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b0, 8'h00, 1'b1, 8'h33, 1'b0);
    tbl[15] = mk(1'b1, 10'd8,    8'h44, 1'b1, 10'd3,    1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    tbl[16] = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd8,    1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
    tbl[17] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 8'hA5, 1'b1, 8'h44, 1'b0);
    tbl[18] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
    tbl[19] = mk(1'b1, 10'd1000, 8'hFF, 1'b1, 10'd1023, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[20] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tbl[21] = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd999,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[22] = mk(1'b0, 10'd0,    8'h00, 1'b1, 10'd1023, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    tbl[23] = mk(1'b1, 10'd1000, 8'hEE, 1'b0, 10'd0,    1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    tbl[24] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tbl[25] = mk(1'b0, 10'd0,    8'h00, 1'b0, 10'd0,    1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset values while rsta is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_doutb", 32'({doutb2, doutb1}), 32'(0));
    check("rst_valid", 32'({dv2, dv1}),       32'(0));
    check("rst_busy",  32'({busy2, busy1}),   32'(2'b11));
    check("rst_err",   32'({err2, err1}),     32'(0));

    // Reset release: busy for exactly DEPTH cycles.
    rst = 1'b0;
    count_busy(n2, n1);
    check("init_busy_cycles2", 32'(n2), 32'(DEPTH));
    check("init_busy_cycles1", 32'(n1), 32'(DEPTH));

    // Main vector table.
    for (int i = 0; i < 26; i++) run_row(tbl[i], i);

    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    check("hold_d2", 32'(doutb2), 32'(8'h5A));
    check("hold_d1", 32'(doutb1), 32'(8'h5A));

    // clr_req with a read of address 3 launched in the same cycle; the read
    // completes with the old data. Writes, reads, out-of-range accesses and a
    // second clr_req during the sweep are all ignored.
    @(posedge clk); #1;
    clr_req = 1'b1; reb = 1'b1; addrb = 10'd3;
    @(posedge clk); #1;
    idle_inputs();
    n2 = 0; n1 = 0; nv2 = 0; nv1 = 0; ne = 0; d2 = '0; d1 = '0;
    for (int k = 0; k < 2000; k++) begin
      if (k == 10)  begin wea = 1'b1; addra = 10'd5;    dina = 8'h77; reb = 1'b1; addrb = 10'd5;    end
      if (k == 20)  begin wea = 1'b1; addra = 10'd1000; dina = 8'h66; reb = 1'b1; addrb = 10'd1023; end
      if (k == 200) clr_req = 1'b1;
      @(negedge clk);
      if (dv2) begin nv2++; d2 = doutb2; end
      if (dv1) begin nv1++; d1 = doutb1; end
      if (err2 || err1) ne++;
      if (busy2) n2++;
      if (busy1) n1++;
      if (!busy2 && !busy1) break;
      @(posedge clk); #1;
      idle_inputs();
    end
    check("clr_busy_cycles2", 32'(n2),  32'(DEPTH));
    check("clr_busy_cycles1", 32'(n1),  32'(DEPTH));
    check("clr_nvalid2",      32'(nv2), 32'(1));
    check("clr_nvalid1",      32'(nv1), 32'(1));
    check("clr_inflight_d2",  32'(d2),  32'(8'hA5));
    check("clr_inflight_d1",  32'(d1),  32'(8'hA5));
    check("clr_no_err",       32'(ne),  32'(0));

    rb_addr[0] = 10'd0;   rb_addr[1] = 10'd3; rb_addr[2] = 10'd5;   rb_addr[3] = 10'd7;
    rb_addr[4] = 10'd8;   rb_addr[5] = 10'd500; rb_addr[6] = 10'd999; rb_addr[7] = 10'd9;
    readback(8, "after_clr");

    // Reset in the middle of a sweep (pointer near 400).
    @(posedge clk); #1; wea = 1'b1; addra = 10'd950; dina = 8'h3C;
    @(posedge clk); #1; wea = 1'b0; reb = 1'b1; addrb = 10'd950;
    @(posedge clk); #1; reb = 1'b0; clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("pre_rst_d2",   32'(doutb2), 32'(8'h3C));
    check("pre_rst_d1",   32'(doutb1), 32'(8'h3C));
    check("pre_rst_busy", 32'({busy2, busy1}), 32'(2'b11));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_doutb", 32'({doutb2, doutb1}), 32'(0));
    check("midrst_valid", 32'({dv2, dv1}),       32'(0));
    check("midrst_busy",  32'({busy2, busy1}),   32'(2'b11));
    check("midrst_err",   32'({err2, err1}),     32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy(n2, n1);
    check("midrst_busy_cycles2", 32'(n2), 32'(DEPTH));
    check("midrst_busy_cycles1", 32'(n1), 32'(DEPTH));

    rb_addr[0] = 10'd950; rb_addr[1] = 10'd0; rb_addr[2] = 10'd500; rb_addr[3] = 10'd999;
    readback(4, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
